// File: rtl/mux_scan_seq.sv
// rtl/mux_scan_seq.sv - registered CH-to-1 mux with manual capture and ascending channel scan
module mux_scan_seq #(
    parameter int CH = 16,
    parameter int W  = 1,
    parameter int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*W-1:0] din,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    input  logic [CH-1:0]   en_mask,
    input  logic            start,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

    state_t        state_q;
    logic [CH-1:0] mask_q;
    logic [SW-1:0] idx_q;
    logic [W-1:0]  out_data_q;
    logic [SW-1:0] out_ch_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          done_q;

    logic          hs;
    logic          can_load;
    logic [CH-1:0] mask_next;

    // Index of the lowest set bit; zero when the mask is empty.
    function automatic logic [SW-1:0] lowest(input logic [CH-1:0] m);
        lowest = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (m[k]) lowest = SW'(k);
        end
    endfunction

    // Channel select that yields zero for indices past the last channel.
    function automatic logic [W-1:0] pick(input logic [CH*W-1:0] d, input logic [SW-1:0] s);
        pick = '0;
        for (int k = 0; k < CH; k++) begin
            if (s == SW'(k)) pick = d[k*W +: W];
        end
    endfunction

    // mask_q holds the channels still to be loaded; the current index is cleared on each load.
    assign hs        = out_valid_q && out_ready;
    assign can_load  = (!out_valid_q || hs) && (|mask_q);
    assign mask_next = mask_q & ~(CH'(1) << idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (!mode) begin
                            out_data_q  <= pick(din, sel);
                            out_ch_q    <= sel;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= MAN;
                        end else if (|en_mask) begin
                            mask_q  <= en_mask;
                            idx_q   <= lowest(en_mask);
                            busy_q  <= 1'b1;
                            state_q <= SCAN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                MAN: begin
                    if (hs) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                SCAN: begin
                    if (can_load) begin
                        out_data_q  <= pick(din, idx_q);
                        out_ch_q    <= idx_q;
                        out_valid_q <= 1'b1;
                        mask_q      <= mask_next;
                        idx_q       <= lowest(mask_next);
                    end else if (hs) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
Parametrised, registered CH-to-1 multiplexer with a channel sequencer. It is the successor to the fixed 16-to-1 combinational mux. In manual mode it captures one selected channel per request. In scan mode it walks every enabled channel in ascending order and emits one word per channel over a valid/ready output handshake. It sits between parallel sample sources and a single serial consumer.

Parameters:
CH, 16, number of input channels (2..64, not required to be a power of 2)
W, 1, width of each channel in bits
SW, $clog2(CH), width of channel index (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
din  input  CH*W  packed channel data; channel k = din[k*W +: W]
sel  input  SW  channel index for manual mode
mode  input  1  0 = manual single capture, 1 = scan; sampled only on accepted start
en_mask  input  CH  scan enable per channel; sampled on accepted start
start  input  1  request strobe (one cycle)
out_data  output  W  captured channel data
out_ch  output  SW  index of channel in out_data
out_valid  output  1  out_data/out_ch valid
out_ready  input  1  consumer accepts when out_valid && out_ready
busy  output  1  high while not IDLE
done  output  1  one-cycle pulse when a request completes

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at a clk edge: state=IDLE, out_data=0, out_ch=0, out_valid=0, busy=0, done=0, internal mask and index cleared. Reset mid-scan aborts the scan immediately; no partial words follow.
- States: IDLE, MAN, SCAN.
- IDLE:
  - start accepted only in IDLE. start in MAN or SCAN is ignored, not queued.
  - start with mode=0: next edge loads out_data=din[sel], out_ch=sel, out_valid=1, state=MAN. Latency from start to out_valid is 1 cycle.
  - sel>=CH: out_data=0, out_ch=sel.
- MAN:
  - Hold out_data/out_ch stable while out_valid && !out_ready.
  - On handshake: out_valid=0, done=1 for one cycle, state=IDLE.
- start with mode=1:
  - Latch en_mask into an internal mask; state=SCAN; index = lowest set bit.
  - Mask all zero: no word emitted; next edge done=1, state stays IDLE.
- SCAN:
  - The output register loads din[index] and out_ch=index whenever it is empty, or is being emptied this cycle (out_valid && out_ready).
  - Back-to-back handshakes give one word per cycle.
  - index then advances to the next set mask bit above it.
  - After the highest enabled channel is loaded, no further loads occur. When that word handshakes, out_valid=0, done=1, state=IDLE.
- Data timing: din is sampled at the load edge, not at start. Channel data may change during a scan; each word reflects din at its own load edge.
- Latched config: mode, mask and sel changes after start have no effect until the next accepted start.
- busy = (state != IDLE).
- done is never asserted in the same cycle as a load.
- Stall rule: while out_valid && !out_ready, out_data and out_ch must not change, and index must not advance.

Test Plan:
1. CH=16, W=1, din=16'h3f0a, mode=0, pulse start with sel=0, 1, 6 and 12 in turn (out_ready=1) → out_data=0, 1, 0, 1, out_ch matching sel, each valid 1 cycle after start, each followed by a done pulse.
2. din=16'h3f0a, mode=1, en_mask=16'h1013, out_ready=1 → words on consecutive cycles: (ch0,0), (ch1,1), (ch4,0), (ch12,1); then done pulse, busy drops.
3. Repeat scenario 2 with out_ready=0 for 3 cycles after the first word → (ch0,0) held unchanged for 4 cycles, then the sequence resumes with no word lost or duplicated.
4. en_mask=0, mode=1, start → out_valid never asserts; done=1 exactly one cycle after start; busy stays 0.
5. Reset mid-scan: en_mask=16'hffff, assert rst after the 3rd word → next cycle out_valid=0, busy=0, done=0. A following start restarts from ch0.
6. Ignored inputs: start pulsed and mode toggled during a scan → no effect on the sequence. A second start issued after done is accepted normally.
